// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and widths for the instruction-memory loader
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    INS_LO,
    INS_HI,
    WRITE,
    DONE,
    ERR
  } ldr_state_t;

  localparam int INSTR_W   = 9;
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream valid/ready handshake into the loader
interface prog_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - assembles a length-prefixed byte stream into 9-bit instructions
// and writes them to instruction memory, holding the core in reset until a clean load.
module prog_loader
  import loader_pkg::*;
#(
  parameter int D = 12,
  parameter int W = INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  prog_loader_if.slave       s_in,
  output logic               im_wr_en,
  output logic [D-1:0]       im_addr,
  output logic [W-1:0]       im_dat,
  output logic               core_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [D:0]         words_loaded
);

  localparam int LEN_W     = 8 * HDR_BYTES;
  localparam int MAX_WORDS = 1 << D;

  ldr_state_t         state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         lo_q, lo_d;
  logic [D-1:0]       addr_q, addr_d;
  logic [W-1:0]       dat_q, dat_d;
  logic [D:0]         cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_full;
  logic [D:0]         cnt_inc;
  logic               xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    lo_d     = lo_q;
    addr_d   = addr_q;
    dat_d    = dat_q;
    cnt_d    = cnt_q;
    xfer     = s_in.in_valid && s_in.in_ready;
    len_full = {s_in.in_data, len_q[7:0]};
    cnt_inc  = cnt_q + {{D{1'b0}}, 1'b1};

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_LO;
          cnt_d   = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = s_in.in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = s_in.in_data;
          if (len_full == '0)                       state_d = DONE;
          else if (32'(len_full) > 32'(MAX_WORDS))  state_d = ERR;
          else                                      state_d = INS_LO;
        end
      end
      INS_LO: begin
        if (xfer) begin
          lo_d    = s_in.in_data;
          state_d = INS_HI;
        end
      end
      INS_HI: begin
        if (xfer) begin
          // Address/data are staged here so they are valid during WRITE and hold afterwards.
          if (s_in.in_data[7:1] != 7'd0) begin
            state_d = ERR;
          end else begin
            addr_d  = cnt_q[D-1:0];
            dat_d   = {s_in.in_data[0], lo_q};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_inc;
        if (32'(cnt_inc) == 32'(len_q)) state_d = DONE;
        else                            state_d = INS_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_in.in_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == INS_LO) || (state_q == INS_HI);
  assign im_wr_en      = (state_q == WRITE);
  assign im_addr       = addr_q;
  assign im_dat        = dat_q;
  assign core_hold     = (state_q != DONE);
  assign load_done     = (state_q == DONE);
  assign load_err      = (state_q == ERR);
  assign words_loaded  = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {int addr; int dat;} wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        im_wr_en;
  logic [11:0] im_addr;
  logic [8:0]  im_dat;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [12:0] words_loaded;

  prog_loader_if bus ();

  prog_loader #(.D(12), .W(9)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .s_in         (bus),
    .im_wr_en     (im_wr_en),
    .im_addr      (im_addr),
    .im_dat       (im_dat),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int  tests = 0;
  int  fails = 0;
  wr_t exp_q[$];
  bit  strobe_q[$];
  bit  exp_wr = 1'b0;
  int  m_used;
  bit  m_err;
  int  m_words;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: parse the image straight from the stream format rules.
  task automatic model(input bq_t b);
    int n;
    n = int'({b[1], b[0]});
    strobe_q.delete();
    for (int i = 0; i < b.size(); i++) strobe_q.push_back(1'b0);
    m_used = 2; m_err = 1'b0; m_words = 0;
    if (n > 4096) begin
      m_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        m_used = 4 + 2 * k;
        if (b[3 + 2 * k] > 8'd1) begin
          m_err = 1'b1;
          break;
        end
        exp_q.push_back('{k, int'(b[3 + 2 * k]) * 256 + int'(b[2 + 2 * k])});
        strobe_q[3 + 2 * k] = 1'b1;
        m_words = k + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_wr) begin
      check("wr_strobe", im_wr_en, 1);
      check("wr_pending", exp_q.size(), 32'(exp_q.size() > 0 ? exp_q.size() : 1));
      if (exp_q.size() > 0) begin
        check("wr_addr", im_addr, exp_q[0].addr);
        check("wr_dat", im_dat, exp_q[0].dat);
        void'(exp_q.pop_front());
      end
    end else begin
      check("no_wr", im_wr_en, 0);
    end
    if (im_wr_en) check("ready_in_write", bus.in_ready, 0);
    check("done_err_excl", load_done & load_err, 0);
    check("hold_vs_done", core_hold, !load_done);
    exp_wr = 1'b0;
  end

  task automatic send_byte(input logic [7:0] b, input bit strobe);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    check("byte_accept", bus.in_ready, 1);
    if (bus.in_ready) begin
      @(posedge clk);
      #1;
      exp_wr = strobe;
    end
  endtask

  task automatic run_load(input bq_t b, input bit gaps);
    int budget = 0;
    model(b);
    @(posedge clk);
    #1;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = b[0];
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_after_start", bus.in_ready, 1);
    for (int i = 0; i < m_used; i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          start = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
          start = 1'b0;
        end
      end
      send_byte(b[i], strobe_q[i]);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    if (m_err)             check("err_next_cycle", load_err, 1);
    else if (m_words == 0) check("empty_done_next", load_done, 1);
    while (!(load_done || load_err) && budget < 20) begin
      budget++;
      @(negedge clk);
    end
    check("load_finish", load_done | load_err, 1);
    check("final_err", load_err, m_err);
    check("final_done", load_done, !m_err);
    check("final_hold", core_hold, m_err);
    check("final_ready", bus.in_ready, 0);
    check("final_words", words_loaded, m_words);
    check("writes_drained", exp_q.size(), 0);
  endtask

  bq_t nom, empty, ovs, badhi, full, part;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    nom   = '{8'h03, 8'h00, 8'h12, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h01};
    empty = '{8'h00, 8'h00};
    ovs   = '{8'h01, 8'h10};
    badhi = '{8'h01, 8'h00, 8'h34, 8'h02};
    part  = '{8'h03, 8'h00, 8'h12, 8'h01, 8'hFF};
    full.push_back(8'h00);
    full.push_back(8'h10);
    for (int i = 0; i < 4096; i++) begin
      int v;
      v = (i * 37 + 5) % 512;
      full.push_back(v[7:0]);
      full.push_back({7'd0, v[8]});
    end

    model(nom);
    check("pin_n_writes", exp_q.size(), 3);
    check("pin_dat0", exp_q[0].dat, 'h112);
    check("pin_dat1", exp_q[1].dat, 'h0FF);
    check("pin_dat2", exp_q[2].dat, 'h100);
    check("pin_addr2", exp_q[2].addr, 2);
    exp_q.delete();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.in_ready, 0);
    check("rst_hold", core_hold, 1);
    check("rst_done", load_done, 0);
    check("rst_err", load_err, 0);
    check("rst_words", words_loaded, 0);
    check("rst_addr", im_addr, 0);
    check("rst_dat", im_dat, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    run_load(nom, 1'b0);
    check("nom_words_lit", words_loaded, 3);
    check("nom_hold_lit", core_hold, 0);

    run_load(empty, 1'b0);
    run_load(ovs, 1'b0);
    check("ovs_err_lit", load_err, 1);
    run_load(badhi, 1'b0);
    check("badhi_err_lit", load_err, 1);
    run_load(nom, 1'b0);
    check("reload_done_lit", load_done, 1);

    run_load(nom, 1'b1);
    run_load(nom, 1'b1);

    model(part);
    exp_q.delete();
    model(nom);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < part.size(); i++) send_byte(part[i], strobe_q[i]);
    #1 reset = 1'b0;
    #1;
    check("arst_ready", bus.in_ready, 0);
    check("arst_wr", im_wr_en, 0);
    check("arst_addr", im_addr, 0);
    check("arst_dat", im_dat, 0);
    check("arst_hold", core_hold, 1);
    check("arst_words", words_loaded, 0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", bus.in_ready, 0);
      check("idle_hold", core_hold, 1);
    end
    bus.in_valid = 1'b0;
    run_load(nom, 1'b0);

    run_load(full, 1'b0);
    check("full_words_lit", words_loaded, 4096);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
